// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one DW-bit register among N requesters.
// Define ARB_LOCK_EN to add the lock input that lets the current owner keep back-to-back access.
module shared_reg_arbiter #(
    parameter  int N  = 4,
    parameter  int DW = 8,
    localparam int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] wdata,
`ifdef ARB_LOCK_EN
    input  logic            lock,
`endif
    output logic [N-1:0]    gnt,
    output logic [DW-1:0]   q,
    output logic [IW-1:0]   owner,
    output logic            done,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t        state, state_d;
    logic [IW-1:0] ptr, ptr_d;
    logic [IW-1:0] winner, winner_d;
    logic [IW-1:0] owner_d;
    logic [IW-1:0] arb_winner;
    logic [IW-1:0] hold_winner;
    logic [DW-1:0] q_d;
    logic [N-1:0]  gnt_d;
    logic          done_d;

    // Rotating priority scan: first requester at or after ptr, wrapping modulo N.
    always_comb begin
        int   idx;
        logic found;
        arb_winner = ptr;
        found      = 1'b0;
        idx        = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                arb_winner = IW'(idx);
            end
        end
    end

`ifdef ARB_LOCK_EN
    // A locking owner that is still requesting overrides the rotating pointer.
    assign hold_winner = (lock && req[owner]) ? owner : arb_winner;
`else
    assign hold_winner = arb_winner;
`endif

    // NOTE: every variable driven here gets a default first, so no latch is inferred.
    always_comb begin
        state_d  = state;
        winner_d = winner;
        ptr_d    = ptr;
        q_d      = q;
        owner_d  = owner;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_d  = GRANT;
                    winner_d = arb_winner;
                end
            end
            GRANT: begin
                if (req[winner]) begin
                    q_d     = wdata[int'(winner)*DW +: DW];
                    owner_d = winner;
                    ptr_d   = (winner == IW'(N-1)) ? '0 : winner + 1'b1;
                    state_d = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (|req) begin
                    state_d  = GRANT;
                    winner_d = hold_winner;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        gnt_d = '0;
        if (state_d == GRANT) gnt_d[winner_d] = 1'b1;
        done_d = (state_d == HOLD);
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= IDLE;
            ptr    <= '0;
            winner <= '0;
            q      <= '0;
            owner  <= '0;
            gnt    <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_d;
            ptr    <= ptr_d;
            winner <= winner_d;
            q      <= q_d;
            owner  <= owner_d;
            gnt    <= gnt_d;
            done   <= done_d;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: vector table, fairness scoreboard, async clear.
// The lock sequence is exercised only when ARB_LOCK_EN is defined.
module tb_shared_reg_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            clr;
    logic [N-1:0]    req;
    logic [N*DW-1:0] wdata;
`ifdef ARB_LOCK_EN
    logic            lock;
`endif
    logic [N-1:0]    gnt;
    logic [DW-1:0]   q;
    logic [1:0]      owner;
    logic            done;
    logic            busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string      name;
        logic [3:0] req;
        logic [31:0] wdata;
        logic [3:0] gnt;
        logic [7:0] q;
        logic [1:0] owner;
        logic       done;
        logic       busy;
    } vec_t;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] owner;
        logic [7:0] q;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    shared_reg_arbiter #(.N(N), .DW(DW)) dut (
        .clk   (clk),
        .clr   (clr),
        .req   (req),
        .wdata (wdata),
`ifdef ARB_LOCK_EN
        .lock  (lock),
`endif
        .gnt   (gnt),
        .q     (q),
        .owner (owner),
        .done  (done),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string n, input logic [3:0] r, input logic [31:0] wd,
                       input logic [3:0] g, input logic [7:0] qq, input logic [1:0] o,
                       input logic d, input logic b);
        vec_t v;
        v.name = n; v.req = r; v.wdata = wd; v.gnt = g;
        v.q = qq; v.owner = o; v.done = d; v.busy = b;
        vecs.push_back(v);
    endtask

    initial begin
        int last_done;

        // Expected outputs after the clock edge that follows applying req/wdata.
        add("single_req",  4'b0100, 32'h00A5_0000, 4'b0100, 8'h00, 2'd0, 1'b0, 1'b1);
        add("single_wr",   4'b0100, 32'h00A5_0000, 4'b0000, 8'hA5, 2'd2, 1'b1, 1'b1);
        add("single_idle", 4'b0000, 32'h00A5_0000, 4'b0000, 8'hA5, 2'd2, 1'b0, 1'b0);
        add("wrap_req3",   4'b1000, 32'h3300_0040, 4'b1000, 8'hA5, 2'd2, 1'b0, 1'b1);
        add("wrap_wr3",    4'b1000, 32'h3300_0040, 4'b0000, 8'h33, 2'd3, 1'b1, 1'b1);
        add("wrap_arb0",   4'b1001, 32'h3300_0040, 4'b0001, 8'h33, 2'd3, 1'b0, 1'b1);
        add("wrap_wr0",    4'b1001, 32'h3300_0040, 4'b0000, 8'h40, 2'd0, 1'b1, 1'b1);
        add("wrap_arb3",   4'b1000, 32'h3300_0040, 4'b1000, 8'h40, 2'd0, 1'b0, 1'b1);
        add("wrap_wr3b",   4'b1000, 32'h3300_0040, 4'b0000, 8'h33, 2'd3, 1'b1, 1'b1);
        add("wrap_idle",   4'b0000, 32'h3300_0040, 4'b0000, 8'h33, 2'd3, 1'b0, 1'b0);
        add("abort_gnt",   4'b0010, 32'h0000_7700, 4'b0010, 8'h33, 2'd3, 1'b0, 1'b1);
        add("abort_drop",  4'b0000, 32'h0000_7700, 4'b0000, 8'h33, 2'd3, 1'b0, 1'b0);
        add("abort_retry", 4'b1010, 32'h5500_7700, 4'b0010, 8'h33, 2'd3, 1'b0, 1'b1);
        add("abort_wr",    4'b1010, 32'h5500_7700, 4'b0000, 8'h77, 2'd1, 1'b1, 1'b1);
        add("abort_idle",  4'b0000, 32'h5500_7700, 4'b0000, 8'h77, 2'd1, 1'b0, 1'b0);

        clr   = 1'b0;
        req   = '0;
        wdata = '0;
`ifdef ARB_LOCK_EN
        lock  = 1'b0;
`endif
        #1 clr = 1'b1;
        #2;
        check("rst_gnt",   gnt,   0);
        check("rst_q",     q,     0);
        check("rst_owner", owner, 0);
        check("rst_done",  done,  0);
        check("rst_busy",  busy,  0);
        step();
        clr = 1'b0;

        foreach (vecs[i]) begin
            req   = vecs[i].req;
            wdata = vecs[i].wdata;
            step();
            check({vecs[i].name, "_gnt"},   gnt,   vecs[i].gnt);
            check({vecs[i].name, "_q"},     q,     vecs[i].q);
            check({vecs[i].name, "_owner"}, owner, vecs[i].owner);
            check({vecs[i].name, "_done"},  done,  vecs[i].done);
            check({vecs[i].name, "_busy"},  busy,  vecs[i].busy);
        end

        // Asynchronous clear in the middle of a GRANT cycle (pointer is 2 here).
        req   = 4'b1111;
        wdata = 32'hDEAD_BEEF;
        step();
        check("clr_pre_gnt", gnt, 4'b0100);
        #2 clr = 1'b1;
        #1;
        check("clr_gnt",   gnt,   0);
        check("clr_q",     q,     0);
        check("clr_owner", owner, 0);
        check("clr_done",  done,  0);
        check("clr_busy",  busy,  0);
        step();
        check("clr_hold_q",   q,   0);
        check("clr_hold_gnt", gnt, 0);
        req = '0;
        clr = 1'b0;
        step();

        // Fairness: all four requesting, expected grant/write order 0,1,2,3,0.
        req   = 4'b1111;
        wdata = 32'h1312_1110;
        for (int k = 0; k < 5; k++) begin
            sb_t e;
            e.gnt   = 4'b0001 << (k % 4);
            e.owner = 2'(k % 4);
            e.q     = 8'h10 + 8'(k % 4);
            sb.push_back(e);
        end
        last_done = -1;
        for (int cyc = 0; cyc < 40 && sb.size() != 0; cyc++) begin
            step();
            check("fair_onehot", 32'($countones(gnt) <= 1), 1);
            if (gnt != 0) check("fair_gnt", gnt, sb[0].gnt);
            if (done) begin
                check("fair_q",     q,     sb[0].q);
                check("fair_owner", owner, sb[0].owner);
                if (last_done >= 0) check("fair_spacing", cyc - last_done, 2);
                last_done = cyc;
                void'(sb.pop_front());
                if (sb.size() == 0) req = '0;
            end
        end
        check("fair_drained", sb.size(), 0);
        req = '0;
        step();
        check("fair_idle_busy", busy, 0);
        check("fair_idle_gnt",  gnt,  0);

`ifdef ARB_LOCK_EN
        begin
            logic [3:0] lk_gnt [7];
            lk_gnt = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0010};
            clr = 1'b1;
            #2 clr = 1'b0;
            req   = 4'b0011;
            wdata = 32'h0000_B1A0;
            for (int i = 0; i < 7; i++) begin
                lock = (i < 6);
                step();
                check("lock_gnt", gnt, lk_gnt[i]);
                if (lk_gnt[i] == 4'b0000) begin
                    check("lock_done",  done,  1);
                    check("lock_owner", owner, 0);
                    check("lock_q",     q,     8'hA0);
                end
            end
            req  = '0;
            lock = 1'b0;
            step();
            step();
            check("lock_idle_busy", busy, 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin arbiter that shares one DW-bit storage register among N requesters.
- Each requester raises req with its write data. The block grants one requester at a time, loads that requester's data into the shared register, and signals completion.
- Sits between several producer blocks and a single shared state register on the common clk/clr domain.

Parameters:
- N, 4, number of requesters; legal range 2..8.
- DW, 8, data width of each requester's write data and of the shared register.
- IW (localparam), $clog2(N), width of the owner ID.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  reset, asynchronous, active-high; forces all state to reset values immediately.
- req  input  N  per-requester write request; bit i belongs to requester i.
- wdata  input  N*DW  packed write data; requester i occupies bits [i*DW +: DW].
- gnt  output  N  one-hot grant, registered; at most one bit high.
- q  output  DW  shared register contents.
- owner  output  IW  index of the requester whose data is currently in q.
- done  output  1  one-cycle pulse: q was updated on the previous edge.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (clr=1, asynchronous): state=IDLE, gnt=0, q=0, owner=0, done=0, busy=0, round-robin pointer ptr=0, latched winner=0.
- FSM states:
  - IDLE: gnt=0, done=0. If |req, arbitrate, latch the winner, and go to GRANT. Otherwise stay in IDLE.
  - GRANT: gnt[winner]=1 for exactly one cycle.
    - If req[winner]=1 at the edge: q<=wdata[winner], owner<=winner, ptr<=(winner+1) mod N, go to HOLD.
    - If req[winner]=0 at the edge (requester withdrew): abort. q, owner and ptr are unchanged, done is not pulsed, go to IDLE.
  - HOLD: gnt=0, done=1 for this single cycle. If |req, arbitrate and go directly to GRANT. Otherwise go to IDLE.
- Arbitration: the winner is the first i with req[i]=1, scanning ptr, ptr+1, …, wrapping modulo N.
  - Arbitration is combinational from req and ptr. The result is registered into the latched winner on the transition into GRANT.
- Latency: req rising while IDLE gives gnt high in the next cycle. q updates at the end of the gnt cycle. done is high in the following cycle.
- Throughput: with continuous requests, one write every 2 cycles (GRANT, HOLD, GRANT, …).
- Requesters must hold req and wdata stable until they see gnt. wdata is sampled only on the GRANT edge of the granted requester.
- A requester whose req is still high after its write is treated as a new request and competes again normally. Round-robin guarantees every active requester is served within N grants.
- Requests arriving during GRANT are not seen until the next arbitration point (HOLD or IDLE).
- Pointer wrap: a winner of N-1 sets ptr=0.
- clr asserted mid-GRANT: q is not written, gnt drops immediately, and all state returns to reset values.
- busy = (state != IDLE).

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - Extra input port lock (1 bit, sampled only from the current owner).
  - If lock=1 at the HOLD edge and req[owner]=1, the winner is forced to owner and ptr is ignored, so the owner keeps exclusive back-to-back access.
  - ptr still advances past the owner after each locked write.
  - If req[owner]=0 in HOLD, lock has no effect and normal round-robin applies.
- Not defined: no lock port, pure round-robin behaviour as above.

Test Plan:
- Reset: assert clr mid-simulation with req=4'b1111 → gnt=0, q=8'h00, owner=0, done=0, busy=0 immediately, without waiting for a clock edge.
- Single request: req=4'b0100, wdata[2]=8'hA5 from IDLE → gnt=4'b0100 one cycle later for 1 cycle; next cycle q=8'hA5, owner=2, done=1 for 1 cycle.
- Round-robin fairness: req=4'b1111 held, data 8'h10/8'h11/8'h12/8'h13 → grant order 0,1,2,3,0. q sequence 10,11,12,13,10, one write every 2 cycles.
- Wrap and pointer: after a write by requester 3, req=4'b1001 → requester 0 granted first, then 3.
- Abort: requester 1 granted, req[1] dropped in the GRANT cycle → no done, q unchanged, back to IDLE, ptr unchanged; the next request from 1 is granted normally.
- ARB_LOCK_EN: req=4'b0011, owner 0 holds lock=1 for 3 writes → gnt to 0 three times consecutively. On lock=0, requester 1 is granted next.
